// File: rtl/one_index_emitter.sv
// one_index_emitter: turns "need K entries" into the K lowest set-bit positions of a free mask, one per cycle.
module one_index_emitter #(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1,
  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  req_vld_i,
  output logic                  req_rdy_o,
  input  logic [DATA_WIDTH-1:0] req_mask_i,
  input  logic [CNT_WIDTH-1:0]  req_cnt_i,
  output logic                  idx_vld_o,
  input  logic                  idx_rdy_i,
  output logic [IDX_WIDTH-1:0]  idx_o,
  output logic                  idx_last_o,
  output logic                  done_vld_o,
  output logic [DATA_WIDTH-1:0] granted_mask_o,
  output logic [CNT_WIDTH-1:0]  granted_cnt_o
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_mask_q, rem_mask_d, grant_mask_q, grant_mask_d;
  logic [DATA_WIDTH-1:0] out_mask_q, out_mask_d, low_bit;
  logic [CNT_WIDTH-1:0]  rem_cnt_q, rem_cnt_d, eff_cnt_q, eff_cnt_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d, ones, eff;
  logic [IDX_WIDTH-1:0]  low_idx;
  always_comb begin
    low_idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) if (rem_mask_q[i]) low_idx = IDX_WIDTH'(i);
    ones = '0;
    for (int i = 0; i < DATA_WIDTH; i++) ones = ones + CNT_WIDTH'(req_mask_i[i]);
    eff = (req_cnt_i < ones) ? req_cnt_i : ones;
    low_bit = DATA_WIDTH'(1) << low_idx;
    state_d = state_q;
    rem_mask_d = rem_mask_q;
    grant_mask_d = grant_mask_q;
    rem_cnt_d = rem_cnt_q;
    eff_cnt_d = eff_cnt_q;
    out_mask_d = out_mask_q;
    out_cnt_d = out_cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      rem_cnt_d = '0;
    end else if (state_q == IDLE && req_vld_i) begin
      rem_mask_d = req_mask_i;
      rem_cnt_d = eff;
      eff_cnt_d = eff;
      grant_mask_d = '0;
      state_d = (eff == '0) ? DONE : EMIT;
      if (eff == '0) begin
        out_mask_d = '0;
        out_cnt_d = '0;
      end
    end else if (state_q == EMIT && idx_rdy_i) begin
      rem_mask_d = rem_mask_q & ~low_bit;
      grant_mask_d = grant_mask_q | low_bit;
      rem_cnt_d = rem_cnt_q - CNT_WIDTH'(1);
      // Granted results are captured on the way into DONE so they can hold afterwards.
      if (rem_cnt_q == CNT_WIDTH'(1)) begin
        state_d = DONE;
        out_mask_d = grant_mask_q | low_bit;
        out_cnt_d = eff_cnt_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_mask_q <= '0;
      grant_mask_q <= '0;
      rem_cnt_q <= '0;
      eff_cnt_q <= '0;
      out_mask_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_mask_q <= rem_mask_d;
      grant_mask_q <= grant_mask_d;
      rem_cnt_q <= rem_cnt_d;
      eff_cnt_q <= eff_cnt_d;
      out_mask_q <= out_mask_d;
      out_cnt_q <= out_cnt_d;
    end
  end
  assign req_rdy_o      = state_q == IDLE;
  assign idx_vld_o      = state_q == EMIT;
  assign idx_o          = idx_vld_o ? low_idx : '0;
  assign idx_last_o     = idx_vld_o && rem_cnt_q == CNT_WIDTH'(1);
  assign done_vld_o     = state_q == DONE;
  assign granted_mask_o = out_mask_q;
  assign granted_cnt_o  = out_cnt_q;
endmodule

// File: tb/tb_one_index_emitter.sv
// tb_one_index_emitter: directed requests with a queue scoreboard checked by an independent output monitor.
module tb_one_index_emitter;
  logic       clk = 0, rst = 0, flush_i = 0, req_vld_i = 0, idx_rdy_i = 1;
  logic [7:0] req_mask_i = '0;
  logic [3:0] req_cnt_i = '0;
  logic       req_rdy_o, idx_vld_o, idx_last_o, done_vld_o;
  logic [2:0] idx_o;
  logic [7:0] granted_mask_o;
  logic [3:0] granted_cnt_o;
  logic       w1_vld = 0, w1_rdy, w1_idx_vld, w1_last, w1_done;
  logic [0:0] w1_mask = '0, w1_cnt = '0, w1_idx, w1_gmask, w1_gcnt;
  int checks = 0, errors = 0, done_cnt = 0;
  int idx_q[$], last_q[$], dmask_q[$], dcnt_q[$];

  one_index_emitter #(.DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .req_mask_i(req_mask_i), .req_cnt_i(req_cnt_i), .idx_vld_o(idx_vld_o), .idx_rdy_i(idx_rdy_i),
    .idx_o(idx_o), .idx_last_o(idx_last_o), .done_vld_o(done_vld_o),
    .granted_mask_o(granted_mask_o), .granted_cnt_o(granted_cnt_o));

  one_index_emitter #(.DATA_WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .flush_i(1'b0), .req_vld_i(w1_vld), .req_rdy_o(w1_rdy),
    .req_mask_i(w1_mask), .req_cnt_i(w1_cnt), .idx_vld_o(w1_idx_vld), .idx_rdy_i(1'b1),
    .idx_o(w1_idx), .idx_last_o(w1_last), .done_vld_o(w1_done),
    .granted_mask_o(w1_gmask), .granted_cnt_o(w1_gcnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_idx(input int i, input int l);
    idx_q.push_back(i);
    last_q.push_back(l);
  endtask

  task automatic exp_done(input int m, input int c);
    dmask_q.push_back(m);
    dcnt_q.push_back(c);
  endtask

  task automatic send(input logic [7:0] m, input logic [3:0] c);
    @(posedge clk); #1;
    chk("req_rdy_idle", req_rdy_o, 1);
    req_vld_i = 1; req_mask_i = m; req_cnt_i = c;
    @(posedge clk); #1;
    req_vld_i = 0;
  endtask

  task automatic wait_done(input int exp_n, input string name);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, n, exp_n);
  endtask

  always @(negedge clk) if (rst) begin
    if (idx_vld_o && idx_rdy_i) begin
      if (idx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_idx: got idx %0d expected no index", idx_o);
      end else begin
        chk("idx", idx_o, idx_q.pop_front());
        chk("idx_last", idx_last_o, last_q.pop_front());
      end
    end
    if (done_vld_o) begin
      done_cnt++;
      if (dmask_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done mask %0h expected no done", granted_mask_o);
      end else begin
        chk("granted_mask", granted_mask_o, dmask_q.pop_front());
        chk("granted_cnt", granted_cnt_o, dcnt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pat[6] = '{0, 1, 0, 0, 1, 1};
    int hold[6] = '{4, 4, 5, 5, 5, 6};
    int d0;
    #3;
    chk("rst_req_rdy", req_rdy_o, 1);
    chk("rst_idx_vld", idx_vld_o, 0);
    chk("rst_idx", idx_o, 0);
    chk("rst_last", idx_last_o, 0);
    chk("rst_done", done_vld_o, 0);
    chk("rst_gmask", granted_mask_o, 0);
    chk("rst_gcnt", granted_cnt_o, 0);
    #10 rst = 1;
    // basic two-index grant
    exp_idx(2, 0); exp_idx(4, 1); exp_done(8'h14, 2);
    send(8'b1011_0100, 2);
    wait_done(3, "lat_basic");
    // single-entry build
    @(posedge clk); #1;
    w1_vld = 1; w1_mask = 1'b1; w1_cnt = 1'b1;
    @(posedge clk); #1;
    w1_vld = 0;
    @(negedge clk);
    chk("w1_idx_vld", w1_idx_vld, 1);
    chk("w1_idx", w1_idx, 0);
    chk("w1_last", w1_last, 1);
    @(negedge clk);
    chk("w1_done", w1_done, 1);
    chk("w1_gmask", w1_gmask, 1);
    chk("w1_gcnt", w1_gcnt, 1);
    // count clipping
    exp_idx(1, 0); exp_idx(2, 1); exp_done(8'h06, 2);
    send(8'h06, 5);
    wait_done(3, "lat_clip5");
    exp_idx(1, 0); exp_idx(2, 1); exp_done(8'h06, 2);
    send(8'h06, 9);
    wait_done(3, "lat_clip9");
    // zero effective count
    exp_done(0, 0);
    send(8'hFF, 0);
    wait_done(1, "lat_cnt0");
    exp_done(0, 0);
    send(8'h00, 3);
    wait_done(1, "lat_mask0");
    // backpressure
    exp_idx(4, 0); exp_idx(5, 0); exp_idx(6, 1); exp_done(8'h70, 3);
    send(8'hF0, 3);
    for (int i = 0; i < 6; i++) begin
      idx_rdy_i = pat[i][0];
      @(negedge clk);
      chk("stall_idx", idx_o, hold[i]);
      chk("stall_req_rdy", req_rdy_o, 0);
      @(posedge clk); #1;
    end
    idx_rdy_i = 1;
    wait_done(1, "lat_stall");
    // flush after first handshake
    exp_idx(4, 0);
    d0 = done_cnt;
    send(8'hF0, 4);
    @(posedge clk); #1;
    flush_i = 1; idx_rdy_i = 0;
    @(posedge clk); #1;
    flush_i = 0; idx_rdy_i = 1;
    @(negedge clk);
    chk("flush_req_rdy", req_rdy_o, 1);
    chk("flush_idx_vld", idx_vld_o, 0);
    @(negedge clk); #1;
    chk("flush_no_done", done_cnt, d0);
    exp_idx(0, 1); exp_done(8'h01, 1);
    send(8'h01, 1);
    wait_done(2, "lat_after_flush");
    // async reset mid-emit
    exp_idx(0, 0); exp_idx(1, 0);
    send(8'hFF, 8);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("arst_idx_vld", idx_vld_o, 0);
    chk("arst_idx", idx_o, 0);
    chk("arst_req_rdy", req_rdy_o, 1);
    chk("arst_done", done_vld_o, 0);
    chk("arst_gmask", granted_mask_o, 0);
    chk("arst_gcnt", granted_cnt_o, 0);
    chk("arst_consumed", idx_q.size(), 0);
    idx_q.delete(); last_q.delete();
    #2 rst = 1;
    @(negedge clk);
    chk("arst_idle", req_rdy_o, 1);
    chk("end_idx_q_empty", idx_q.size(), 0);
    chk("end_done_q_empty", dmask_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
